// File: rtl/crc_engine_param.sv
// crc_engine_param: bit-serial CRC generator/checker with serial CRC shift-out and strobe-gated progress.
module crc_engine_param #(
  parameter int                 CRC_W = 15,
  parameter logic [CRC_W-1:0]   POLY  = 15'h4599,
  parameter logic [CRC_W-1:0]   INIT  = '0,
  parameter int                 LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_en,
  input  logic             din,
  output logic             busy,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_bit,
  output logic             crc_bit_valid,
  output logic             done,
  output logic             crc_ok
);
  typedef enum logic [2:0] {IDLE, CALC, SHIFT, CHECK, DONE} state_t;
  state_t             r_state, w_next;
  logic [CRC_W-1:0]   r_crc, w_crc_upd, w_sh;
  logic [LEN_W-1:0]   r_cnt, r_len;
  logic               r_mode, w_fb, w_last_len, w_last_crc;
  assign w_fb       = din ^ r_crc[CRC_W-1];
  assign w_crc_upd  = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  assign w_last_len = r_cnt == r_len - LEN_W'(1);
  assign w_last_crc = r_cnt == LEN_W'(CRC_W-1);
  assign w_sh       = r_crc << r_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (start) w_next = (frame_len != '0) ? CALC : (mode ? CHECK : SHIFT);
      CALC:        if (bit_en && w_last_len) w_next = r_mode ? CHECK : SHIFT;
      SHIFT, CHECK: if (bit_en && w_last_crc) w_next = DONE;
      default:     w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_crc   <= INIT;
      r_cnt   <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_crc  <= INIT;
          r_cnt  <= '0;
          r_mode <= mode;
          r_len  <= frame_len;
        end
        CALC: if (bit_en) begin
          r_crc <= w_crc_upd;
          r_cnt <= w_last_len ? '0 : r_cnt + LEN_W'(1);
        end
        SHIFT: if (bit_en) r_cnt <= w_last_crc ? '0 : r_cnt + LEN_W'(1);
        CHECK: if (bit_en) begin
          r_crc <= w_crc_upd;
          r_cnt <= w_last_crc ? '0 : r_cnt + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end
  assign busy          = r_state == CALC || r_state == SHIFT || r_state == CHECK;
  assign crc_out       = r_crc;
  assign crc_bit_valid = r_state == SHIFT;
  assign crc_bit       = crc_bit_valid & w_sh[CRC_W-1];
  assign done          = r_state == DONE;
  // result stays visible in IDLE until the next start reloads mode and crc
  assign crc_ok        = r_mode && r_crc == '0 && (r_state == DONE || r_state == IDLE);
endmodule

// File: tb/tb_crc_engine_param.sv
// tb_crc_engine_param: table-driven and randomized checks against a polynomial-division CRC model.
module tb_crc_engine_param;
  logic        clk = 0, rst = 1, start = 0, mode = 0, bit_en = 0, din = 0;
  logic [15:0] frame_len = '0;
  logic        busy, crc_bit, crc_bit_valid, done, crc_ok;
  logic [14:0] crc_out;
  int checks = 0, errors = 0;
  localparam logic [15:0] G = 16'hC599;

  crc_engine_param dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .frame_len(frame_len),
    .bit_en(bit_en), .din(din), .busy(busy), .crc_out(crc_out), .crc_bit(crc_bit),
    .crc_bit_valid(crc_bit_valid), .done(done), .crc_ok(crc_ok)
  );

  always #5 clk = ~clk;

  // remainder of msg(x) * x^15 divided by G(x), by long division
  function automatic logic [14:0] ref_crc(input logic [63:0] msg, input int n);
    logic [79:0] v;
    v = 80'(msg) << 15;
    for (int i = n + 14; i >= 15; i--)
      if (v[i]) v = v ^ (80'(G) << (i - 15));
    return v[14:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input bit m, input int n, input logic [63:0] data, input int gap, input bit poke,
                     output logic [14:0] crc, output logic ok, output logic [14:0] sh,
                     output int bcyc, output bit to, output bit pulse_bad);
    int total, idx, cyc;
    bit fin;
    total = n + (m ? 15 : 0);
    idx = 0; cyc = 0; bcyc = 0; sh = '0; fin = 0; to = 0; pulse_bad = 0; crc = '0; ok = 0;
    start = 1; mode = m; frame_len = 16'(n); bit_en = 0; din = 0;
    @(posedge clk); #1;
    start = 0;
    while (!fin) begin
      bit_en = gap == 0 ? 1'b1 : gap == 1 ? ~cyc[0] : 1'($urandom_range(0, 1));
      din = (bit_en && idx < total) ? data[total-1-idx] : 1'b0;
      if (poke && cyc == 5) begin start = 1; mode = ~m; frame_len = 16'd3; end
      else begin start = 0; mode = m; frame_len = 16'(n); end
      #4;
      if (busy) bcyc++;
      if (crc_bit_valid && bit_en) sh = {sh[13:0], crc_bit};
      if (done) begin fin = 1; crc = crc_out; ok = crc_ok; start = poke; end
      if (bit_en) idx++;
      cyc++;
      if (!fin && cyc > 4 * (total + 40)) begin fin = 1; to = 1; end
      @(posedge clk); #1;
    end
    start = 0; bit_en = 0;
    #4;
    pulse_bad = done || busy || (crc_ok !== ok);
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    bit          m;
    int          n;
    logic [63:0] data;
    int          gap;
    bit          poke;
    logic [14:0] exp_crc;
    bit          exp_ok;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [14:0] crc, sh;
    logic ok;
    int bcyc;
    bit to, pb;
    vt[0] = '{"gen1", 0, 1, 64'h1, 0, 0, 15'h4599, 0};
    vt[1] = '{"gen2", 0, 2, 64'h2, 0, 0, 15'h4EAB, 0};
    vt[2] = '{"chk_good", 1, 2, {47'd0, 2'b10, 15'h4EAB}, 0, 0, 15'h0000, 1};
    vt[3] = '{"chk_bad", 1, 2, {47'd0, 2'b10, 15'h4EAA}, 0, 0, 15'h4599, 0};
    vt[4] = '{"gen_len0", 0, 0, 64'h0, 0, 0, 15'h0000, 0};
    vt[5] = '{"gen_abcd", 0, 16, 64'hABCD, 1, 1, ref_crc(64'hABCD, 16), 0};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_crc", crc_out, 0);
    chk("rst_outs", {done, crc_bit, crc_bit_valid, crc_ok}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      run(vt[i].m, vt[i].n, vt[i].data, vt[i].gap, vt[i].poke, crc, ok, sh, bcyc, to, pb);
      chk({vt[i].name, "_timeout"}, to, 0);
      chk({vt[i].name, "_crc"}, crc, vt[i].exp_crc);
      chk({vt[i].name, "_ok"}, ok, vt[i].exp_ok);
      chk({vt[i].name, "_shift"}, sh, vt[i].m ? 15'h0 : vt[i].exp_crc);
      chk({vt[i].name, "_after_done"}, pb, 0);
      if (vt[i].gap == 0) chk({vt[i].name, "_busy"}, bcyc, vt[i].n + 15);
      else chk({vt[i].name, "_busy_range"}, (bcyc >= 2 * (vt[i].n + 15) - 1 && bcyc <= 2 * (vt[i].n + 15) + 1), 1);
    end

    // asynchronous reset in the middle of CALC after 8 of 16 bits
    start = 1; mode = 0; frame_len = 16'd16;
    @(posedge clk); #1;
    start = 0; bit_en = 1;
    for (int i = 0; i < 8; i++) begin
      din = 1'(16'hABCD >> (15 - i));
      @(posedge clk); #1;
    end
    bit_en = 0;
    chk("mid_crc", crc_out, ref_crc(64'hAB, 8));
    chk("mid_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_crc", crc_out, 0);
    chk("arst_outs", {done, crc_bit_valid, crc_ok}, 0);
    @(posedge clk); #1;
    rst = 0;
    run(0, 16, 64'hABCD, 0, 0, crc, ok, sh, bcyc, to, pb);
    chk("post_rst_timeout", to, 0);
    chk("post_rst_crc", crc, ref_crc(64'hABCD, 16));

    for (int k = 0; k < 24; k++) begin
      bit m;
      int n;
      logic [63:0] d, stream;
      logic [14:0] c, exp_c;
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 40);
      d = {$urandom, $urandom} & ((64'd1 << n) - 1);
      c = ref_crc(d, n);
      if (m && $urandom_range(0, 1)) c = c ^ 15'($urandom_range(1, 32767));
      stream = m ? ((d << 15) | 64'(c)) : d;
      exp_c = ref_crc(stream, m ? n + 15 : n);
      run(m, n, stream, $urandom_range(0, 2), 0, crc, ok, sh, bcyc, to, pb);
      chk($sformatf("rnd%0d_timeout", k), to, 0);
      chk($sformatf("rnd%0d_crc", k), crc, exp_c);
      chk($sformatf("rnd%0d_ok", k), ok, m && exp_c == 0);
      chk($sformatf("rnd%0d_shift", k), sh, m ? 15'h0 : exp_c);
      chk($sformatf("rnd%0d_after_done", k), pb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
